// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multiply/divide sequencer of the multicycle MIPS
// datapath: the sequencer state encoding and the op-select constants used to
// pick between the iterative multiplier and divider units.
// -----------------------------------------------------------------------------
package muldiv_pkg;

  // Sequencer states. IDLE must be zero so the reset state is all-zeros.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    WRITE = 3'd3,
    EXC   = 3'd4
  } state_t;

  // Operation select carried with the start request (also the HI/LO mux code).
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Sequencer for the iterative multiplier and divider units. The main control
// FSM issues a one-cycle start for MULT or DIV and stalls on busy. This block
// initialises the chosen unit, drives its step enable for N_STEPS cycles,
// writes HI/LO from that unit and pulses done.
//
// Optional feature: define MULDIV_DIVZERO_EN to turn a DIV with a zero divisor
// into a one-cycle divide-by-zero exception instead of a normal divide.
//
// Ports:
//   clock         in   system clock, all state on posedge
//   reset         in   asynchronous active-high reset
//   start         in   operation request, sampled only in IDLE
//   op            in   0 = MULT, 1 = DIV, sampled with start
//   divisor_zero  in   B register == 0, sampled with start
//   abort         in   synchronous cancel of a running operation
//   busy          out  high in every state except IDLE
//   done          out  one-cycle completion pulse
//   unit_init     out  load operands into the selected unit
//   mult_op       out  multiplier step enable
//   div_op        out  divider step enable
//   hi_write      out  HI register write enable
//   lo_write      out  LO register write enable
//   mux_hi        out  HI source select (0 = multiplier, 1 = divider)
//   mux_lo        out  LO source select (0 = multiplier, 1 = divider)
//   div_zero_exc  out  divide-by-zero exception pulse
// -----------------------------------------------------------------------------
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int N_STEPS = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic op,
  input  logic divisor_zero,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic unit_init,
  output logic mult_op,
  output logic div_op,
  output logic hi_write,
  output logic lo_write,
  output logic mux_hi,
  output logic mux_lo,
  output logic div_zero_exc
);

  localparam int CW = $clog2(N_STEPS);
  localparam logic [CW-1:0] COUNT_LOAD = CW'(N_STEPS - 1);

  state_t          r_state;
  state_t          w_nextState;
  logic [CW-1:0]   r_count;
  logic            r_opQ;
  logic            w_accept;
  logic            w_takeExc;

  // A request is taken only from IDLE, and a simultaneous abort cancels it.
  assign w_accept = (r_state == IDLE) && start && !abort;

  // Decide whether an accepted request diverts to the divide-by-zero
  // exception. Without the feature the divisor flag has no effect at all.
`ifdef MULDIV_DIVZERO_EN
  assign w_takeExc = (op == OP_DIV) && divisor_zero;
`else
  logic w_unusedDivZero;
  assign w_unusedDivZero = divisor_zero;
  assign w_takeExc       = 1'b0;
`endif

  // Next-state logic. abort pulls any active state back to IDLE; WRITE and EXC
  // are single-cycle states. RUN leaves once the counter has reached zero,
  // which gives exactly N_STEPS cycles in RUN after the N_STEPS-1 load.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = w_takeExc ? EXC : INIT;
        end
      end
      INIT: begin
        w_nextState = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          w_nextState = IDLE;
        end else if (r_count == '0) begin
          w_nextState = WRITE;
        end
      end
      WRITE:   w_nextState = IDLE;
      EXC:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register and the op latch. op is captured only on the accepting
  // edge so it stays stable for the whole operation regardless of the input.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_opQ   <= OP_MULT;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_opQ <= op;
      end
    end
  end

  // Iteration counter: loaded during INIT, counts down in RUN and saturates
  // at zero so it can never wrap back to a large value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_state == INIT) begin
      r_count <= COUNT_LOAD;
    end else if ((r_state == RUN) && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Moore output decode from the registered state and op latch.
  assign busy      = (r_state != IDLE);
  assign unit_init = (r_state == INIT);
  assign mult_op   = (r_state == RUN) && (r_opQ == OP_MULT);
  assign div_op    = (r_state == RUN) && (r_opQ == OP_DIV);
  assign hi_write  = (r_state == WRITE);
  assign lo_write  = (r_state == WRITE);
  assign mux_hi    = (r_state == WRITE) && r_opQ;
  assign mux_lo    = (r_state == WRITE) && r_opQ;

`ifdef MULDIV_DIVZERO_EN
  assign done         = (r_state == WRITE) || (r_state == EXC);
  assign div_zero_exc = (r_state == EXC);
`else
  assign done         = (r_state == WRITE);
  assign div_zero_exc = 1'b0;
`endif

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Sequencer for the iterative multiplier and divider units in the multicycle MIPS datapath. The main control FSM issues a one-cycle start request for MULT or DIV and stalls while busy is high. This block then does four things: initialises the selected unit, drives its step enable for a fixed number of cycles, writes HI/LO from that unit, and reports completion. This replaces the inline iteration counter in the main control FSM.

## Interface
- N_STEPS, 32, iteration count per operation (≥2); counter width = $clog2(N_STEPS)
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- start  in  1  operation request, sampled only in IDLE
- op  in  1  0 = MULT, 1 = DIV; sampled with start
- divisor_zero  in  1  B register == 0, sampled with start
- abort  in  1  synchronous cancel
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- unit_init  out  1  load operands into selected unit
- mult_op  out  1  multiplier step enable
- div_op  out  1  divider step enable
- hi_write, lo_write  out  1  HI/LO register write enables
- mux_hi, mux_lo  out  1  HI/LO source select: 0 = multiplier, 1 = divider
- div_zero_exc  out  1  divide-by-zero exception pulse

## Operation
- States: IDLE, INIT, RUN, WRITE, EXC.
- All outputs are Moore-decoded from the registered state and op_q.
- IDLE to INIT: start=1 and abort=0. The edge latches op into op_q.
- INIT, one cycle:
  - unit_init=1.
  - Counter loads N_STEPS-1.
  - Next state is RUN.
- RUN:
  - mult_op=~op_q and div_op=op_q.
  - The counter decrements each cycle.
  - When count==0, next state is WRITE. The counter never wraps.
- WRITE, one cycle:
  - hi_write=lo_write=1.
  - mux_hi=mux_lo=op_q.
  - done=1.
  - Next state is IDLE.
- abort=1 in INIT, RUN, WRITE or EXC: next state is IDLE. No HI/LO write and no done are produced after the abort edge. abort in IDLE is ignored, and it beats a simultaneous start.
- start while busy is ignored and is not queued.
- op and divisor_zero are don't-care outside the start edge.

## Timing
- Reset values:
  - State IDLE, counter 0, op_q 0.
  - Every output 0; mux_hi/mux_lo 0.
- With the start-sampling edge as E0:
  - INIT occupies cycle 1.
  - RUN occupies cycles 2 to N_STEPS+1, giving exactly N_STEPS step enables.
  - WRITE and done occur in cycle N_STEPS+2.
  - HI/LO are updated at the edge that ends that cycle.
- busy is high from cycle 1 through cycle N_STEPS+2 inclusive, and low in the cycle after WRITE.
- Back-to-back: a new start can be sampled on the first IDLE edge after WRITE, so the issue interval is N_STEPS+3 cycles.
- Reset asserted mid-operation returns immediately to reset values with no writes.

## Configuration
- MULDIV_DIVZERO_EN defined:
  - start with op=1 and divisor_zero=1 goes to EXC instead of INIT.
  - EXC lasts one cycle with div_zero_exc=1, done=1 and busy=1.
  - No unit_init, div_op or HI/LO write occurs.
  - Next state is IDLE.
- MULDIV_DIVZERO_EN undefined:
  - divisor_zero is ignored and the divide runs normally.
  - div_zero_exc is tied to 0 and EXC is unreachable.

## Structure
- Shared package muldiv_pkg:
  - State enum: IDLE=3'd0, INIT, RUN, WRITE, EXC.
  - Constants OP_MULT=1'b0 and OP_DIV=1'b1.
- No sub-module: counter and FSM stay in one module.

## Test plan
- Reset released, start=1, op=0, N_STEPS=32:
  - unit_init in cycle 1.
  - mult_op high cycles 2–33; div_op stays 0.
  - hi_write, lo_write and done high in cycle 34 with mux_hi=mux_lo=0.
  - busy low in cycle 35.
- start=1, op=1, divisor_zero=0: div_op high for exactly 32 cycles; WRITE with mux_hi=mux_lo=1; done in cycle 34.
- abort=1 at RUN cycle 10 of a DIV: IDLE next cycle; no hi_write, no done; a following start runs a full 32 steps.
- start pulses repeated during RUN: ignored; single done at cycle 34. start and abort asserted together in IDLE: stays IDLE.
- op=1, divisor_zero=1:
  - MULDIV_DIVZERO_EN defined: div_zero_exc=done=1 in cycle 1; no div_op or writes.
  - MULDIV_DIVZERO_EN undefined: normal 34-cycle divide.
- Asynchronous reset pulsed mid-RUN, between edges: all outputs 0 immediately; state IDLE.
